// File: rtl/gate_check_pkg.sv
// gate_check_pkg
//   Shared definitions for the gate truth-table checker: the checker's FSM
//   state encoding and reference truth tables for 2-input gates.
//   A truth table's bit i is the expected gate output when the gate inputs
//   carry the value i (bit 0 = in_a, bit 1 = in_b).
package gate_check_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } gate_check_state_t;

  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_NOR  = 4'b0001;
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_XOR  = 4'b0110;

endpackage

// File: rtl/gate_truth_checker_if.sv
// gate_truth_checker_if
//   Bundles the checker's run handshake, the stimulus/response link to the
//   gate under test, and the result outputs.
//   slave  : the checker (drives stim and results, reads start and dut_out)
//   master : the environment / gate side (drives start and dut_out)
//   Signals:
//     start     run request, honoured only when the checker is idle or done
//     stim      gate input pattern, N_INPUTS bits
//     dut_out   gate output
//     busy      run in progress
//     done      run complete, results valid
//     pass      no pattern mismatched (valid while done)
//     fail_vec  bit i set when pattern i mismatched
//     err_count number of mismatching patterns
interface gate_truth_checker_if #(
  parameter int N_INPUTS = 2
) ();

  logic                     start;
  logic [N_INPUTS-1:0]      stim;
  logic                     dut_out;
  logic                     busy;
  logic                     done;
  logic                     pass;
  logic [2**N_INPUTS-1:0]   fail_vec;
  logic [N_INPUTS:0]        err_count;

  modport slave (
    input  start, dut_out,
    output stim, busy, done, pass, fail_vec, err_count
  );

  modport master (
    output start, dut_out,
    input  stim, busy, done, pass, fail_vec, err_count
  );

endinterface

// File: rtl/gate_check_settle_ctr.sv
// gate_check_settle_ctr
//   Settle timer for the checker. Down-counter loaded with SETTLE_CYCLES-1
//   on clear; decrements while enabled and stops at zero. tc_o is high on
//   the last settle cycle, so an enabled count from a fresh clear spans
//   exactly SETTLE_CYCLES cycles.
//   Ports:
//     clk, rst_n  clock and asynchronous active-low reset
//     clr_i       reload the counter
//     en_i        count down
//     tc_o        terminal count (counter == 0)
module gate_check_settle_ctr #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int LOAD_I = SETTLE_CYCLES - 1;
  localparam logic [CW-1:0] LOAD = LOAD_I[CW-1:0];

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = LOAD;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= LOAD;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/gate_truth_checker.sv
// gate_truth_checker
//   Exhaustive self-test of a combinational gate. Steps stim through every
//   input pattern, holds each for SETTLE_CYCLES cycles, then samples dut_out
//   and compares it (case equality, so X/Z fails) against TRUTH[pattern].
//   Reports a per-pattern fail map, a mismatch count and a pass flag.
//   Ports:
//     clk, rst_n  clock and asynchronous active-low reset
//     bus         gate_truth_checker_if.slave (handshake, stim, results)
//   Build option:
//     GATE_CHECK_STOP_ON_FAIL_EN  end the run at the first mismatch
//
//   state  | meaning
//   -------+-------------------------------------------------
//   IDLE   | after reset, stim = 0, waiting for start
//   SETTLE | stim = pattern, letting the gate output settle
//   SAMPLE | compare dut_out with TRUTH[pattern], record result
//   DONE   | results held, done = 1, start launches a new run
module gate_truth_checker
  import gate_check_pkg::*;
#(
  parameter int                     N_INPUTS      = 2,
  parameter int                     SETTLE_CYCLES = 2,
  parameter logic [2**N_INPUTS-1:0] TRUTH         = TT_NAND
) (
  input  logic                 clk,
  input  logic                 rst_n,
  gate_truth_checker_if.slave  bus
);

  localparam int NPAT   = 2**N_INPUTS;
  localparam int LAST_I = NPAT - 1;
  // One bit wider than the pattern index so the last pattern compares
  // unambiguously and the counter never wraps within a run.
  localparam logic [N_INPUTS:0] LAST = LAST_I[N_INPUTS:0];

  gate_check_state_t   state_q, state_d;
  logic [N_INPUTS:0]   pattern_q, pattern_d;
  logic [NPAT-1:0]     fail_q, fail_d;
  logic [N_INPUTS:0]   err_q, err_d;
  logic                pass_q, pass_d;
  logic                ctr_clr, ctr_en, ctr_tc;
  logic                exp_bit, mismatch, stop;

  gate_check_settle_ctr #(
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) u_settle_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (ctr_clr),
    .en_i  (ctr_en),
    .tc_o  (ctr_tc)
  );

  assign exp_bit  = TRUTH[pattern_q[N_INPUTS-1:0]];
  assign mismatch = (bus.dut_out !== exp_bit);

  always_comb begin
    state_d   = state_q;
    pattern_d = pattern_q;
    fail_d    = fail_q;
    err_d     = err_q;
    pass_d    = pass_q;
    ctr_clr   = 1'b0;
    ctr_en    = 1'b0;
    stop      = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d   = SETTLE;
          pattern_d = '0;
          fail_d    = '0;
          err_d     = '0;
          pass_d    = 1'b0;
          ctr_clr   = 1'b1;
        end
      end

      SETTLE: begin
        ctr_en = 1'b1;
        if (ctr_tc) begin
          state_d = SAMPLE;
        end
      end

      SAMPLE: begin
        if (mismatch) begin
          fail_d[pattern_q[N_INPUTS-1:0]] = 1'b1;
          err_d = err_q + 1'b1;
        end
`ifdef GATE_CHECK_STOP_ON_FAIL_EN
        stop = (pattern_q == LAST) || mismatch;
`else
        stop = (pattern_q == LAST);
`endif
        if (stop) begin
          state_d = DONE;
          pass_d  = (err_d == '0);
        end else begin
          state_d   = SETTLE;
          pattern_d = pattern_q + 1'b1;
          ctr_clr   = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pattern_q <= '0;
      fail_q    <= '0;
      err_q     <= '0;
      pass_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pattern_q <= pattern_d;
      fail_q    <= fail_d;
      err_q     <= err_d;
      pass_q    <= pass_d;
    end
  end

  // pattern_q is cleared on acceptance and held in DONE, so stim is 0 in
  // IDLE and keeps the last driven pattern once the run ends.
  assign bus.stim      = pattern_q[N_INPUTS-1:0];
  assign bus.busy      = (state_q == SETTLE) || (state_q == SAMPLE);
  assign bus.done      = (state_q == DONE);
  assign bus.pass      = pass_q;
  assign bus.fail_vec  = fail_q;
  assign bus.err_count = err_q;

endmodule

// File: tb/tb_gate_truth_checker.sv
module tb_gate_truth_checker;
  import gate_check_pkg::*;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  int   mode;   // 0 NAND, 1 AND, 2 stuck at 1, 3 NAND with X on pattern 2

  gate_truth_checker_if #(.N_INPUTS(2)) bus ();

  gate_truth_checker #(
    .N_INPUTS      (2),
    .SETTLE_CYCLES (2),
    .TRUTH         (TT_NAND)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    case (mode)
      1:       bus.dut_out = bus.stim[0] & bus.stim[1];
      2:       bus.dut_out = 1'b1;
      3:       bus.dut_out = (bus.stim == 2'd2) ? 1'bx : ~(bus.stim[0] & bus.stim[1]);
      default: bus.dut_out = ~(bus.stim[0] & bus.stim[1]);
    endcase
  end

  // Pulse start for one cycle; returns #1 after the accepting edge.
  task automatic start_run();
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Counts edges from acceptance until done; a timeout is a failure.
  task automatic wait_done(output int cycles);
    cycles = 0;
    while (bus.done !== 1'b1 && cycles < 200) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    if (bus.done !== 1'b1) begin
      n_tests++; n_fail++;
      $display("FAIL wait_done: done=%b after %0d cycles, required 1", bus.done, cycles);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if ({bus.stim, bus.busy, bus.done, bus.pass, bus.fail_vec, bus.err_count} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: stim=%0d busy=%b done=%b pass=%b fail_vec=%b err=%0d, required all 0",
               bus.stim, bus.busy, bus.done, bus.pass, bus.fail_vec, bus.err_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.stim !== 2'd0) begin
      n_fail++;
      $display("FAIL idle_after_reset: busy=%b done=%b stim=%0d, required 0 0 0",
               bus.busy, bus.done, bus.stim);
    end
  endtask

  task automatic test_nand_pass();
    mode = 0;
    start_run();
    for (int k = 0; k < 12; k++) begin
      n_tests++;
      if (bus.stim !== 2'(k / 3) || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
        n_fail++;
        $display("FAIL nand_seq[%0d]: stim=%0d busy=%b done=%b, required stim=%0d busy=1 done=0",
                 k, bus.stim, bus.busy, bus.done, k / 3);
      end
      @(posedge clk);
      #1;
    end
    n_tests++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL nand_done_at_12: done=%b busy=%b, required done=1 busy=0", bus.done, bus.busy);
    end
    n_tests++;
    if (bus.pass !== 1'b1 || bus.fail_vec !== 4'b0000 || bus.err_count !== 3'd0) begin
      n_fail++;
      $display("FAIL nand_result: pass=%b fail_vec=%b err=%0d, required pass=1 fail_vec=0000 err=0",
               bus.pass, bus.fail_vec, bus.err_count);
    end
  endtask

  task automatic test_and_gate();
    int cyc, exp_cyc, exp_err;
    logic [3:0] exp_fail;
    logic [1:0] exp_stim;
`ifdef GATE_CHECK_STOP_ON_FAIL_EN
    exp_cyc = 3;  exp_fail = 4'b0001; exp_err = 1; exp_stim = 2'd0;
`else
    exp_cyc = 12; exp_fail = 4'b1111; exp_err = 4; exp_stim = 2'd3;
`endif
    mode = 1;
    start_run();
    wait_done(cyc);
    n_tests++;
    if (cyc !== exp_cyc) begin
      n_fail++;
      $display("FAIL and_run_length: %0d cycles, required %0d", cyc, exp_cyc);
    end
    n_tests++;
    if (bus.pass !== 1'b0 || bus.fail_vec !== exp_fail || bus.err_count !== 3'(exp_err) || bus.stim !== exp_stim) begin
      n_fail++;
      $display("FAIL and_result: pass=%b fail_vec=%b err=%0d stim=%0d, required pass=0 fail_vec=%b err=%0d stim=%0d",
               bus.pass, bus.fail_vec, bus.err_count, bus.stim, exp_fail, exp_err, exp_stim);
    end
  endtask

  task automatic test_stuck_one();
    int cyc;
    mode = 2;
    start_run();
    wait_done(cyc);
    n_tests++;
    if (cyc !== 12) begin
      n_fail++;
      $display("FAIL stuck1_run_length: %0d cycles, required 12", cyc);
    end
    n_tests++;
    if (bus.pass !== 1'b0 || bus.fail_vec !== 4'b1000 || bus.err_count !== 3'd1 || bus.stim !== 2'd3) begin
      n_fail++;
      $display("FAIL stuck1_result: pass=%b fail_vec=%b err=%0d stim=%0d, required pass=0 fail_vec=1000 err=1 stim=3",
               bus.pass, bus.fail_vec, bus.err_count, bus.stim);
    end
    mode = 0;   // results must hold in DONE regardless of the gate output
    repeat (6) @(posedge clk);
    #1;
    n_tests++;
    if (bus.done !== 1'b1 || bus.fail_vec !== 4'b1000 || bus.err_count !== 3'd1 || bus.stim !== 2'd3) begin
      n_fail++;
      $display("FAIL stuck1_hold: done=%b fail_vec=%b err=%0d stim=%0d, required done=1 fail_vec=1000 err=1 stim=3",
               bus.done, bus.fail_vec, bus.err_count, bus.stim);
    end
  endtask

  task automatic test_start_held();
    int cyc;
    mode = 0;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    n_tests++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.stim !== 2'd0) begin
      n_fail++;
      $display("FAIL held_accept: busy=%b done=%b stim=%0d, required busy=1 done=0 stim=0",
               bus.busy, bus.done, bus.stim);
    end
    repeat (5) @(posedge clk);
    #1;
    n_tests++;
    if (bus.busy !== 1'b1 || bus.stim !== 2'd1) begin
      n_fail++;
      $display("FAIL held_ignored: busy=%b stim=%0d at cycle 5, required busy=1 stim=1", bus.busy, bus.stim);
    end
    repeat (7) @(posedge clk);
    #1;
    n_tests++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.pass !== 1'b1) begin
      n_fail++;
      $display("FAIL held_done_at_12: done=%b busy=%b pass=%b, required 1 0 1", bus.done, bus.busy, bus.pass);
    end
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    n_tests++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b1 || bus.stim !== 2'd0 || bus.pass !== 1'b0) begin
      n_fail++;
      $display("FAIL held_restart: done=%b busy=%b stim=%0d pass=%b, required done=0 busy=1 stim=0 pass=0",
               bus.done, bus.busy, bus.stim, bus.pass);
    end
    wait_done(cyc);
    n_tests++;
    if (cyc !== 12 || bus.pass !== 1'b1) begin
      n_fail++;
      $display("FAIL held_second_run: %0d cycles pass=%b, required 12 cycles pass=1", cyc, bus.pass);
    end
  endtask

  task automatic test_reset_mid_run();
    int bad;
    mode = 1;
    start_run();
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({bus.stim, bus.busy, bus.done, bus.pass, bus.fail_vec, bus.err_count} !== 11'd0) begin
      n_fail++;
      $display("FAIL midreset_outputs: stim=%0d busy=%b done=%b pass=%b fail_vec=%b err=%0d, required all 0",
               bus.stim, bus.busy, bus.done, bus.pass, bus.fail_vec, bus.err_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk);
      #1;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.err_count !== 3'd0) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL midreset_idle: %0d cycles with done/busy/err nonzero, required 0", bad);
    end
  endtask

  task automatic test_x_pattern();
    int cyc, exp_cyc;
    logic [1:0] exp_stim;
`ifdef GATE_CHECK_STOP_ON_FAIL_EN
    exp_cyc = 9;  exp_stim = 2'd2;
`else
    exp_cyc = 12; exp_stim = 2'd3;
`endif
    mode = 3;
    start_run();
    wait_done(cyc);
    n_tests++;
    if (cyc !== exp_cyc || bus.stim !== exp_stim) begin
      n_fail++;
      $display("FAIL x_timing: %0d cycles stim=%0d, required %0d cycles stim=%0d", cyc, bus.stim, exp_cyc, exp_stim);
    end
    n_tests++;
    if (bus.pass !== 1'b0 || bus.fail_vec !== 4'b0100 || bus.err_count !== 3'd1) begin
      n_fail++;
      $display("FAIL x_result: pass=%b fail_vec=%b err=%0d, required pass=0 fail_vec=0100 err=1",
               bus.pass, bus.fail_vec, bus.err_count);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    mode = 0;
    start_run();
    n_tests++;
    if (bus.fail_vec !== 4'b0000 || bus.err_count !== 3'd0 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_cleared: fail_vec=%b err=%0d done=%b, required 0000 0 0",
               bus.fail_vec, bus.err_count, bus.done);
    end
    wait_done(cyc);
    n_tests++;
    if (cyc !== 12 || bus.pass !== 1'b1 || bus.fail_vec !== 4'b0000) begin
      n_fail++;
      $display("FAIL b2b_result: %0d cycles pass=%b fail_vec=%b, required 12 1 0000", cyc, bus.pass, bus.fail_vec);
    end
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    mode      = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    test_reset();
    test_nand_pass();
    test_and_gate();
    test_stuck_one();
    test_start_held();
    test_reset_mid_run();
    test_x_pattern();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
